image_loader: RTL and testbench

//  Writer side of the 784-byte image RAM. Takes the received byte stream
//  (UART RX, one byte per rx_valid pulse), detects a sync byte, writes the

---
 rtl/image_loader_pkg.sv | 14 +
 rtl/image_loader_byte_timeout_counter.sv | 43 ++++
 rtl/image_loader.sv | 147 ++++++++++++++
 tb/tb_image_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/image_loader_pkg.sv
// Shared image-buffer constants used by the loader, the image RAM and the inference FSM.
package image_loader_pkg;

  localparam int         IMG_NUM_PIXELS     = 784;
  localparam int         IMG_ADDR_W         = 10;
  localparam logic [7:0] IMG_SYNC_BYTE      = 8'hAA;
  localparam int         IMG_TIMEOUT_CYCLES = 1000000;

  // Width of a counter that must reach max_val - 1; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/image_loader_byte_timeout_counter.sv
// Inter-byte idle counter: clears on demand, counts while enabled, flags expiry at its terminal count.
module byte_timeout_counter
  import image_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = IMG_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, then saturating increment at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/image_loader.sv
// Image RAM writer: waits for a sync byte, stores the following pixel bytes, then holds
// image_ready until the consumer acknowledges. A stalled stream aborts the load.
module image_loader
  import image_loader_pkg::*;
#(
  parameter int         NUM_PIXELS     = IMG_NUM_PIXELS,
  parameter int         ADDR_W         = IMG_ADDR_W,
  parameter logic [7:0] SYNC_BYTE      = IMG_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = IMG_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  output logic              ram_wr_en,
  output logic              image_ready,
  input  logic              image_ack,
  output logic              loading,
  output logic              load_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } load_state_e;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              ready_q, ready_d;
  logic              loading_q, loading_d;
  logic              error_q, error_d;
  logic              in_load_s;
  logic              tmo_expired_s;
  logic              tmo_clear_s;
  logic              tmo_enable_s;

  assign in_load_s    = (state_q == ST_LOAD);
  // Counter only runs while loading; any accepted byte restarts the window.
  assign tmo_clear_s  = !in_load_s || rx_valid;
  assign tmo_enable_s = in_load_s && !rx_valid;

  byte_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (tmo_clear_s),
    .enable_i (tmo_enable_s),
    .expired_o(tmo_expired_s)
  );

  // State, pixel counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      wr_en_q   <= 1'b0;
      ready_q   <= 1'b0;
      loading_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      ready_q   <= ready_d;
      loading_q <= loading_d;
      error_q   <= error_d;
    end
  end

  // Next-state decode. In LOAD an arriving byte beats a simultaneous timeout expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (rx_valid && (pix_cnt_q == LAST_PIX)) begin
          state_d = ST_READY;
        end else if (!rx_valid && tmo_expired_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_READY: begin
        if (image_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values, registered above so every output lags its cause by one edge.
  always_comb begin
    wr_en_d   = in_load_s && rx_valid;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pix_cnt_d = pix_cnt_q;
    if (wr_en_d) begin
      wr_addr_d = pix_cnt_q;
      wr_data_d = rx_data;
      if (pix_cnt_q == LAST_PIX) begin
        pix_cnt_d = '0;
      end else begin
        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
      end
    end else if (state_q == ST_IDLE) begin
      pix_cnt_d = '0;
    end else begin
      pix_cnt_d = pix_cnt_q;
    end
    ready_d   = (state_d == ST_READY);
    loading_d = (state_d == ST_LOAD);
    error_d   = in_load_s && !rx_valid && tmo_expired_s;
  end

  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_wr_en   = wr_en_q;
  assign image_ready = ready_q;
  assign loading     = loading_q;
  assign load_error  = error_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: full loads, sync filtering, timeout, READY lockout and async reset.
module tb_image_loader;

  localparam int NPIX = 784;
  localparam int TMO  = 64;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [9:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       ram_wr_en;
  logic       image_ready;
  logic       image_ack;
  logic       loading;
  logic       load_error;

  int n_checks = 0;
  int n_pass   = 0;

  image_loader #(
    .NUM_PIXELS    (NPIX),
    .ADDR_W        (10),
    .SYNC_BYTE     (8'hAA),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_wr_en  (ram_wr_en),
    .image_ready(image_ready),
    .image_ack  (image_ack),
    .loading    (loading),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one byte for one clock; returns #1 after the sampling edge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    image_ack = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_wr_en",   32'(ram_wr_en),   32'd0);
    chk("rst_addr",    32'(ram_wr_addr), 32'd0);
    chk("rst_data",    32'(ram_wr_data), 32'd0);
    chk("rst_ready",   32'(image_ready), 32'd0);
    chk("rst_loading", 32'(loading),     32'd0);
    chk("rst_error",   32'(load_error),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycle();

    // Full image with a gap cycle after each byte.
    send(8'hAA);
    chk("t1_sync_loading", 32'(loading),   32'd1);
    chk("t1_sync_nowrite", 32'(ram_wr_en), 32'd0);
    for (int i = 0; i < NPIX; i++) begin
      send(8'(i));
      chk("t1_wr_en",   32'(ram_wr_en),   32'd1);
      chk("t1_addr",    32'(ram_wr_addr), 32'(i));
      chk("t1_data",    32'(ram_wr_data), 32'(i % 256));
      chk("t1_ready",   32'(image_ready), 32'(i == NPIX - 1));
      chk("t1_loading", 32'(loading),     32'(i != NPIX - 1));
      if (i < NPIX - 1) begin
        idle_cycle();
        chk("t1_gap_wr_en", 32'(ram_wr_en),   32'd0);
        chk("t1_gap_addr",  32'(ram_wr_addr), 32'(i));
      end
    end

    // READY refuses traffic, including a sync byte.
    for (int k = 0; k < 11; k++) begin
      send((k == 0) ? 8'hAA : 8'(k));
      chk("t4_no_wr",    32'(ram_wr_en),   32'd0);
      chk("t4_ready",    32'(image_ready), 32'd1);
      chk("t4_addr_hold", 32'(ram_wr_addr), 32'd783);
    end
    // Ack with a simultaneous sync byte: byte dropped, back to IDLE.
    image_ack = 1'b1;
    send(8'hAA);
    image_ack = 1'b0;
    chk("t4_ack_ready",   32'(image_ready), 32'd0);
    chk("t4_ack_nowr",    32'(ram_wr_en),   32'd0);
    chk("t4_ack_loading", 32'(loading),     32'd0);

    // Next image, back-to-back bytes every cycle.
    send(8'hAA);
    chk("t6_sync_loading", 32'(loading), 32'd1);
    for (int i = 0; i < NPIX; i++) begin
      send(8'(i * 3));
      chk("t6_wr_en", 32'(ram_wr_en),   32'd1);
      chk("t6_addr",  32'(ram_wr_addr), 32'(i));
      chk("t6_data",  32'(ram_wr_data), 32'((i * 3) % 256));
      chk("t6_ready", 32'(image_ready), 32'(i == NPIX - 1));
    end
    idle_cycle();
    chk("t6_ready_held", 32'(image_ready), 32'd1);
    chk("t6_wr_en_off",  32'(ram_wr_en),   32'd0);
    image_ack = 1'b1;
    idle_cycle();
    image_ack = 1'b0;
    chk("t6_ack_ready", 32'(image_ready), 32'd0);

    // Non-sync bytes in IDLE are discarded; an ack there does nothing.
    image_ack = 1'b1;
    send(8'h12);
    image_ack = 1'b0;
    chk("t2_12_nowr",    32'(ram_wr_en), 32'd0);
    chk("t2_12_loading", 32'(loading),   32'd0);
    send(8'h55);
    chk("t2_55_nowr",    32'(ram_wr_en), 32'd0);
    chk("t2_55_loading", 32'(loading),   32'd0);
    send(8'hAA);
    chk("t2_sync_loading", 32'(loading),   32'd1);
    chk("t2_sync_nowr",    32'(ram_wr_en), 32'd0);
    send(8'hAA);
    chk("t2_aa_wr",   32'(ram_wr_en),   32'd1);
    chk("t2_aa_addr", 32'(ram_wr_addr), 32'd0);
    chk("t2_aa_data", 32'(ram_wr_data), 32'hAA);

    // 100 more bytes (one carrying an ignored ack), then silence.
    for (int i = 1; i <= 100; i++) begin
      image_ack = (i == 50);
      send(8'(i + 1));
      image_ack = 1'b0;
      chk("t3_wr_en", 32'(ram_wr_en),   32'd1);
      chk("t3_addr",  32'(ram_wr_addr), 32'(i));
    end
    for (int c = 1; c < TMO; c++) begin
      idle_cycle();
      chk("t3_no_err",  32'(load_error), 32'd0);
      chk("t3_loading", 32'(loading),    32'd1);
    end
    idle_cycle();
    chk("t3_err_pulse",   32'(load_error), 32'd1);
    chk("t3_err_loading", 32'(loading),    32'd0);
    idle_cycle();
    chk("t3_err_once", 32'(load_error), 32'd0);
    send(8'hAA);
    send(8'h5A);
    chk("t3_resync_addr", 32'(ram_wr_addr), 32'd0);
    chk("t3_resync_data", 32'(ram_wr_data), 32'h5A);

    // Reset in the middle of a load.
    for (int i = 1; i <= 400; i++) begin
      send(8'(i + 7));
      chk("t5_addr", 32'(ram_wr_addr), 32'(i));
    end
    chk("t5_pre_wr_en", 32'(ram_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_wr_en",   32'(ram_wr_en),   32'd0);
    chk("t5_async_addr",    32'(ram_wr_addr), 32'd0);
    chk("t5_async_data",    32'(ram_wr_data), 32'd0);
    chk("t5_async_loading", 32'(loading),     32'd0);
    chk("t5_async_ready",   32'(image_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(8'h12);
      chk("t5_nosync_wr",    32'(ram_wr_en),   32'd0);
      chk("t5_nosync_ready", 32'(image_ready), 32'd0);
    end
    send(8'hAA);
    for (int i = 0; i < NPIX; i++) begin
      send(8'(255 - (i % 256)));
      chk("t5_full_addr",  32'(ram_wr_addr), 32'(i));
      chk("t5_full_ready", 32'(image_ready), 32'(i == NPIX - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
